// File: rtl/dmx_uart_loader.sv
// dmx_uart_loader: 8N1 UART receiver plus packet parser that turns framed
// channel-update packets (A5, ADDR_HI, ADDR_LO, COUNT, data...) into
// single-cycle writes to the 512-channel DMX universe RAM.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rx           asynchronous UART line, idle high
//   wr_en        one-cycle RAM write strobe
//   wr_addr      channel index 0..511, held between writes
//   wr_data      channel value, held between writes
//   frame_done   one-cycle pulse on the last data byte of a packet
//   err_frame    one-cycle pulse when a stop bit samples low
//   err_proto    one-cycle pulse on an ADDR_HI byte with bits 7:1 set
//   err_timeout  one-cycle pulse when a packet stalls too long between bytes
//   busy         high while the parser is not hunting for a sync byte
module dmx_uart_loader #(
    parameter int unsigned clock_hz       = 12000000,
    parameter int unsigned baud           = 115200,
    parameter int unsigned timeout_cycles = 120000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic       wr_en,
    output logic [8:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       err_frame,
    output logic       err_proto,
    output logic       err_timeout,
    output logic       busy
);

    localparam int unsigned DIV   = clock_hz / baud;
    localparam int unsigned BIT_W = $clog2(DIV + 1);
    localparam int unsigned TO_W  = $clog2(timeout_cycles + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HUNT, P_ADDR_HI, P_ADDR_LO, P_COUNT, P_DATA} p_state_t;

    rx_state_t        rx_state_q;
    p_state_t         p_state_q;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             addr_hi_q;
    logic [9:0]       ptr_q;
    logic [8:0]       remain_q;
    logic [TO_W-1:0]  to_cnt_q;

    // A bit period expires when the down-counter reaches 1, so a reload
    // with DIV gives exactly DIV clocks between samples.
    logic rx_tick_c, byte_valid_c, frame_bad_c;
    assign rx_tick_c    = (bit_cnt_q == BIT_W'(1));
    assign byte_valid_c = (rx_state_q == R_STOP) && rx_tick_c && rx_sync_q;
    assign frame_bad_c  = (rx_state_q == R_STOP) && rx_tick_c && !rx_sync_q;

    // Synchronizer and 8N1 bit receiver
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= R_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            case (rx_state_q)
                R_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= R_START;
                        bit_cnt_q  <= BIT_W'(DIV / 2);
                    end
                end
                R_START: begin
                    if (rx_tick_c) begin
                        if (rx_sync_q) begin
                            rx_state_q <= R_IDLE;   // glitch, not a start bit
                            bit_cnt_q  <= '0;
                        end else begin
                            rx_state_q <= R_DATA;
                            bit_cnt_q  <= BIT_W'(DIV);
                            bit_idx_q  <= '0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_tick_c) begin
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_cnt_q <= BIT_W'(DIV);
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= R_STOP;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_tick_c) begin
                        rx_state_q <= R_IDLE;
                        bit_cnt_q  <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    // Packet parser, inter-byte timeout and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_state_q   <= P_HUNT;
            addr_hi_q   <= 1'b0;
            ptr_q       <= '0;
            remain_q    <= '0;
            to_cnt_q    <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            err_frame   <= 1'b0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            frame_done  <= 1'b0;
            err_frame   <= 1'b0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
            if (frame_bad_c) begin
                err_frame <= 1'b1;
                p_state_q <= P_HUNT;
                busy      <= 1'b0;
                to_cnt_q  <= '0;
            end else if (byte_valid_c) begin
                // A byte arriving wins over a timeout in the same clock.
                to_cnt_q <= '0;
                case (p_state_q)
                    P_HUNT: begin
                        if (shift_q == 8'hA5) begin
                            p_state_q <= P_ADDR_HI;
                            busy      <= 1'b1;
                        end
                    end
                    P_ADDR_HI: begin
                        if (shift_q[7:1] != 7'd0) begin
                            err_proto <= 1'b1;
                            p_state_q <= P_HUNT;
                            busy      <= 1'b0;
                        end else begin
                            addr_hi_q <= shift_q[0];
                            p_state_q <= P_ADDR_LO;
                        end
                    end
                    P_ADDR_LO: begin
                        ptr_q     <= {1'b0, addr_hi_q, shift_q};
                        p_state_q <= P_COUNT;
                    end
                    P_COUNT: begin
                        remain_q  <= (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
                        p_state_q <= P_DATA;
                    end
                    P_DATA: begin
                        // Pointer past 511 consumes the byte without writing.
                        if (!ptr_q[9]) begin
                            wr_en   <= 1'b1;
                            wr_addr <= ptr_q[8:0];
                            wr_data <= shift_q;
                        end
                        ptr_q    <= ptr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == 9'd1) begin
                            frame_done <= 1'b1;
                            p_state_q  <= P_HUNT;
                            busy       <= 1'b0;
                        end
                    end
                    default: begin
                        p_state_q <= P_HUNT;
                        busy      <= 1'b0;
                    end
                endcase
            end else if (p_state_q == P_HUNT) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_W'(timeout_cycles - 1)) begin
                err_timeout <= 1'b1;
                p_state_q   <= P_HUNT;
                busy        <= 1'b0;
                to_cnt_q    <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmx_uart_loader.sv
// Directed bench for dmx_uart_loader: drives 8N1 bytes on rx and checks the
// RAM write stream, pulse outputs and busy against hand-computed values.
// Parameters are scaled (16 clocks/bit, 3000-clock timeout) to keep runs short.
module tb_dmx_uart_loader;

    localparam int unsigned CLK_HZ = 1600000;
    localparam int unsigned BAUD   = 100000;
    localparam int unsigned TO     = 3000;
    localparam int unsigned DIV    = CLK_HZ / BAUD;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done, err_frame, err_proto, err_timeout, busy;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    dmx_uart_loader #(
        .clock_hz       (CLK_HZ),
        .baud           (BAUD),
        .timeout_cycles (TO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx          (rx),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .err_frame   (err_frame),
        .err_proto   (err_proto),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    // Output monitor: logs writes and counts cycles each pulse is high.
    logic [8:0] wa_q[$];
    logic [7:0] wd_q[$];
    int fd_cnt = 0, fd_wr = 0, fd_busy_low = 0;
    int ef_cnt = 0, ep_cnt = 0, et_cnt = 0;

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            if (wr_en === 1'b1) fd_wr++;
            if (busy === 1'b0) fd_busy_low++;
        end
        if (err_frame === 1'b1)   ef_cnt++;
        if (err_proto === 1'b1)   ep_cnt++;
        if (err_timeout === 1'b1) et_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clock);
        end
        rx = stop;
        repeat (DIV) @(negedge clock);
        rx = 1'b1;
        repeat (DIV) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [8:0] a, input logic [7:0] d);
        check(tag, 32'({wa_q[idx], wd_q[idx]}), 32'({a, d}));
    endtask

    int n0, f0, e0, bad;

    initial begin
        // Reset state
        repeat (4) @(negedge clock);
        check("reset_pulses_busy", 32'({wr_en, frame_done, err_frame, err_proto, err_timeout, busy}), 32'd0);
        check("reset_addr_data", 32'({wr_addr, wr_data}), 32'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);

        // Basic 3-byte packet
        n0 = wa_q.size(); f0 = fd_cnt;
        send(8'hA5); send(8'h00); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33);
        check("A_nwrites", 32'(wa_q.size() - n0), 32'd3);
        check_wr("A_w0", n0,     9'd0, 8'h11);
        check_wr("A_w1", n0 + 1, 9'd1, 8'h22);
        check_wr("A_w2", n0 + 2, 9'd2, 8'h33);
        check("A_frame_done", 32'(fd_cnt - f0), 32'd1);
        check("A_fd_with_write", 32'(fd_wr), 32'd1);
        check("A_fd_busy_low", 32'(fd_busy_low), 32'd1);
        check("A_busy_idle", 32'(busy), 32'd0);

        // Packet running off the end of the universe
        n0 = wa_q.size(); f0 = fd_cnt;
        send(8'hA5); send(8'h01); send(8'hFE); send(8'h04);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        check("B_nwrites", 32'(wa_q.size() - n0), 32'd2);
        check_wr("B_w510", n0,     9'd510, 8'hAA);
        check_wr("B_w511", n0 + 1, 9'd511, 8'hBB);
        check("B_frame_done", 32'(fd_cnt - f0), 32'd1);
        check("B_held_addr_data", 32'({wr_addr, wr_data}), 32'({9'd511, 8'hBB}));

        // Bad ADDR_HI then a good packet
        n0 = wa_q.size();
        send(8'hA5); send(8'h02);
        check("C_err_proto", 32'(ep_cnt), 32'd1);
        check("C_busy_after_proto", 32'(busy), 32'd0);
        check("C_no_write", 32'(wa_q.size() - n0), 32'd0);
        send(8'hA5); send(8'h00); send(8'h05); send(8'h01); send(8'h7F);
        check("C_nwrites", 32'(wa_q.size() - n0), 32'd1);
        check_wr("C_w5", n0, 9'd5, 8'h7F);

        // Framing error during DATA
        n0 = wa_q.size(); f0 = fd_cnt;
        send(8'hA5); send(8'h00); send(8'h20); send(8'h02); send(8'h44);
        send_byte(8'h55, 1'b0);
        check("D_err_frame", 32'(ef_cnt), 32'd1);
        check("D_nwrites", 32'(wa_q.size() - n0), 32'd1);
        check_wr("D_w20", n0, 9'h020, 8'h44);
        check("D_busy_hunt", 32'(busy), 32'd0);
        send(8'h66);
        check("D_no_write_after", 32'(wa_q.size() - n0), 32'd1);
        check("D_no_frame_done", 32'(fd_cnt - f0), 32'd0);

        // Inter-byte timeout
        n0 = wa_q.size();
        send(8'hA5); send(8'h00); send(8'h10);
        check("E_busy_in_packet", 32'(busy), 32'd1);
        repeat (TO - 100) @(negedge clock);
        check("E_no_early_timeout", 32'(et_cnt), 32'd0);
        for (int i = 0; i < 400 && et_cnt == 0; i++) @(negedge clock);
        repeat (4) @(negedge clock);
        check("E_timeout_once", 32'(et_cnt), 32'd1);
        check("E_busy_low", 32'(busy), 32'd0);
        check("E_no_writes", 32'(wa_q.size() - n0), 32'd0);

        // Quarter-bit glitch between bytes of a packet
        n0 = wa_q.size(); f0 = fd_cnt; e0 = ef_cnt;
        send(8'hA5); send(8'h00); send(8'h30); send(8'h01);
        rx = 1'b0;
        repeat (DIV / 4) @(negedge clock);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clock);
        send(8'h5A);
        check("F_nwrites", 32'(wa_q.size() - n0), 32'd1);
        check_wr("F_w30", n0, 9'h030, 8'h5A);
        check("F_no_err_frame", 32'(ef_cnt - e0), 32'd0);
        check("F_frame_done", 32'(fd_cnt - f0), 32'd1);

        // COUNT=0 means 256 bytes
        n0 = wa_q.size(); f0 = fd_cnt;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'((i * 7 + 3) & 255));
        check("G_nwrites", 32'(wa_q.size() - n0), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (wa_q[n0 + i] !== 9'(256 + i) || wd_q[n0 + i] !== 8'((i * 7 + 3) & 255)) bad++;
        end
        check("G_stream_mismatches", 32'(bad), 32'd0);
        check("G_frame_done", 32'(fd_cnt - f0), 32'd1);
        check("G_busy_low", 32'(busy), 32'd0);

        // Reset mid-byte inside a packet
        n0 = wa_q.size();
        send(8'hA5); send(8'h00); send(8'h50); send(8'h02); send(8'h11);
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("H_reset_busy", 32'(busy), 32'd0);
        check("H_reset_addr_data", 32'({wr_addr, wr_data}), 32'd0);
        rx = 1'b1;
        repeat (DIV) @(negedge clock);
        reset_n = 1'b1;
        repeat (2 * DIV) @(negedge clock);
        send(8'h22); send(8'h33);
        check("H_no_write_after_reset", 32'(wa_q.size() - n0), 32'd1);
        send(8'hA5); send(8'h00); send(8'h07); send(8'h01); send(8'h99);
        check("H_nwrites", 32'(wa_q.size() - n0), 32'd2);
        check_wr("H_w7", n0 + 1, 9'd7, 8'h99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
